// File: rtl/imem_read_responder.sv
// Instruction-memory fetch responder: synchronous RAM read into a 2-entry in-order response FIFO,
// with a side load port for writing the program image.
module imem_read_responder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        occ_q, occ_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [1:0]        buf_err_q;

    logic              accept, pop, req_err;
    logic [AW-1:0]     req_idx;

    assign req_idx = req_addr[AW+1:2];
    // Upper bits must be zero so addresses past the RAM never alias onto it.
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

    // Depends only on registered occupancy and load_en, never on rsp_ready.
    assign req_ready = !load_en && (occ_q != 2'd2);
    assign rsp_valid = (occ_q != 2'd0);
    assign busy      = (occ_q != 2'd0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_data = rsp_valid ? buf_data_q[rd_ptr_q] : '0;
    assign rsp_err  = rsp_valid ? buf_err_q[rd_ptr_q] : 1'b0;

    always_comb begin
        occ_d = occ_q;
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // RAM is neither reset nor initialised; it survives reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q         <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            buf_err_q     <= 2'b00;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
        end else begin
            occ_q <= occ_d;
            if (accept) begin
                buf_data_q[wr_ptr_q] <= req_err ? '0 : mem[req_idx];
                buf_err_q[wr_ptr_q]  <= req_err;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule
